// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: CP0 register file, exception/eret sequencer and timer.
// Ports:
//   i_clk, i_rst             clock, synchronous active-high reset
//   i_ext_int                hardware interrupt lines (level)
//   i_cp0_wen/ren/addr/wdata mtc0 / mfc0 access; o_cp0_rdata is combinational
//   i_exc_*                  exception commit (code, pc, delay slot, address)
//   i_eret                   eret commit strobe
//   o_int_req                registered interrupt request to commit stage
//   o_flush, o_new_pc        one-cycle pipeline flush and redirect PC
module cp0_exc_ctrl #(
   parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
   parameter int          IP_HW_W    = 6
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [IP_HW_W-1:0] i_ext_int,
   input  logic               i_cp0_wen,
   input  logic               i_cp0_ren,
   input  logic [4:0]         i_cp0_addr,
   input  logic [31:0]        i_cp0_wdata,
   output logic [31:0]        o_cp0_rdata,
   input  logic               i_exc_valid,
   input  logic [4:0]         i_exc_code,
   input  logic [31:0]        i_exc_pc,
   input  logic               i_exc_bd,
   input  logic [31:0]        i_exc_badvaddr,
   input  logic               i_eret,
   output logic               o_int_req,
   output logic               o_flush,
   output logic [31:0]        o_new_pc
);

   localparam logic [4:0] A_BADVADDR = 5'd8;
   localparam logic [4:0] A_COUNT    = 5'd9;
   localparam logic [4:0] A_COMPARE  = 5'd11;
   localparam logic [4:0] A_STATUS   = 5'd12;
   localparam logic [4:0] A_CAUSE    = 5'd13;
   localparam logic [4:0] A_EPC      = 5'd14;

   typedef enum logic {S_IDLE, S_FLUSH} state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [31:0]        r_badvaddr;
   logic [31:0]        r_count;
   logic [31:0]        r_compare;
   logic [7:0]         r_im;
   logic               r_exl;
   logic               r_ie;
   logic               r_bd;
   logic               r_ti;
   logic [IP_HW_W-1:0] r_ip_hw;
   logic [1:0]         r_ip_sw;
   logic [4:0]         r_exccode;
   logic [31:0]        r_epc;
   logic               r_tick;
   logic               r_int_req;
   logic [31:0]        r_new_pc;

   logic        w_idle;
   logic        w_do_exc;
   logic        w_do_eret;
   logic        w_do_wr;
   logic        w_wr_count;
   logic        w_wr_compare;
   logic        w_wr_status;
   logic        w_wr_cause;
   logic        w_wr_epc;
   logic [31:0] w_count_inc;
   logic [31:0] w_status;
   logic [31:0] w_cause;
   logic [7:0]  w_ip;
   logic [IP_HW_W-1:0] w_ti_vec;

   // Requests in FLUSH belong to flushed instructions and are dropped.
   assign w_idle    = (r_state == S_IDLE);
   assign w_do_exc  = w_idle & i_exc_valid;
   assign w_do_eret = w_idle & ~i_exc_valid & i_eret;
   assign w_do_wr   = w_idle & ~i_exc_valid & ~i_eret & i_cp0_wen;

   assign w_wr_count   = w_do_wr & (i_cp0_addr == A_COUNT);
   assign w_wr_compare = w_do_wr & (i_cp0_addr == A_COMPARE);
   assign w_wr_status  = w_do_wr & (i_cp0_addr == A_STATUS);
   assign w_wr_cause   = w_do_wr & (i_cp0_addr == A_CAUSE);
   assign w_wr_epc     = w_do_wr & (i_cp0_addr == A_EPC);

   assign w_count_inc = r_count + 32'd1;
   assign w_ip        = {r_ip_hw, r_ip_sw};
   assign w_ti_vec    = {r_ti, {(IP_HW_W-1){1'b0}}};

   assign w_status = {9'd0, 1'b1, 6'd0, r_im, 6'd0, r_exl, r_ie};
   assign w_cause  = {r_bd, r_ti, 14'd0, r_ip_hw, r_ip_sw,
                      1'b0, r_exccode, 2'b00};

   // FSM: state register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM: next state
   always_comb begin
      w_state_nxt = S_IDLE;
      unique case (r_state)
         S_IDLE:  w_state_nxt = (w_do_exc | w_do_eret) ? S_FLUSH : S_IDLE;
         S_FLUSH: w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      o_flush  = (r_state == S_FLUSH);
      o_new_pc = r_new_pc;
   end

   // Redirect target captured with the request
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_new_pc <= 32'd0;
      end else if (w_do_exc) begin
         r_new_pc <= EXC_VECTOR;
      end else if (w_do_eret) begin
         r_new_pc <= r_epc;
      end
   end

   // Count and its half-rate tick
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_tick  <= 1'b0;
         r_count <= 32'd0;
      end else begin
         r_tick <= ~r_tick;
         if (w_wr_count) begin
            r_count <= i_cp0_wdata;
         end else if (r_tick) begin
            r_count <= w_count_inc;
         end
      end
   end

   // Compare and sticky timer interrupt; a Compare write clears TI
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_compare <= 32'd0;
         r_ti      <= 1'b0;
      end else begin
         if (w_wr_compare) begin
            r_compare <= i_cp0_wdata;
            r_ti      <= 1'b0;
         end else if (r_tick && (w_count_inc == r_compare)) begin
            r_ti <= 1'b1;
         end
      end
   end

   // Hardware pending bits and interrupt request
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ip_hw   <= '0;
         r_int_req <= 1'b0;
      end else begin
         r_ip_hw   <= i_ext_int | w_ti_vec;
         r_int_req <= r_ie & ~r_exl & (|(w_ip & r_im));
      end
   end

   // Status, Cause, EPC, BadVAddr
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_im       <= 8'd0;
         r_exl      <= 1'b0;
         r_ie       <= 1'b0;
         r_bd       <= 1'b0;
         r_ip_sw    <= 2'd0;
         r_exccode  <= 5'd0;
         r_epc      <= 32'd0;
         r_badvaddr <= 32'd0;
      end else if (w_do_exc) begin
         // Nested exception keeps the original return context
         if (!r_exl) begin
            r_epc <= i_exc_bd ? (i_exc_pc - 32'd4) : i_exc_pc;
            r_bd  <= i_exc_bd;
         end
         r_exl     <= 1'b1;
         r_exccode <= i_exc_code;
         if ((i_exc_code == 5'd4) || (i_exc_code == 5'd5)) begin
            r_badvaddr <= i_exc_badvaddr;
         end
      end else if (w_do_eret) begin
         r_exl <= 1'b0;
      end else begin
         if (w_wr_status) begin
            r_im  <= i_cp0_wdata[15:8];
            r_exl <= i_cp0_wdata[1];
            r_ie  <= i_cp0_wdata[0];
         end
         if (w_wr_cause) begin
            r_ip_sw <= i_cp0_wdata[9:8];
         end
         if (w_wr_epc) begin
            r_epc <= i_cp0_wdata;
         end
      end
   end

   // mfc0 read mux
   always_comb begin
      o_cp0_rdata = 32'd0;
      if (i_cp0_ren) begin
         case (i_cp0_addr)
            A_BADVADDR: o_cp0_rdata = r_badvaddr;
            A_COUNT:    o_cp0_rdata = r_count;
            A_COMPARE:  o_cp0_rdata = r_compare;
            A_STATUS:   o_cp0_rdata = w_status;
            A_CAUSE:    o_cp0_rdata = w_cause;
            A_EPC:      o_cp0_rdata = r_epc;
            default:    o_cp0_rdata = 32'd0;
         endcase
      end
   end

   assign o_int_req = r_int_req;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// tb_cp0_exc_ctrl: directed literal checks plus randomized traffic
// compared every cycle against a register-array model of CP0.
module tb_cp0_exc_ctrl;

   localparam logic [31:0] VEC = 32'hBFC0_0380;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [5:0]  ext_int = '0;
   logic        wen = 1'b0;
   logic        ren = 1'b0;
   logic [4:0]  addr = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic        exc_valid = 1'b0;
   logic [4:0]  exc_code = '0;
   logic [31:0] exc_pc = '0;
   logic        exc_bd = 1'b0;
   logic [31:0] exc_badvaddr = '0;
   logic        eret = 1'b0;
   logic        int_req;
   logic        flush;
   logic [31:0] new_pc;

   int checks = 0;
   int failures = 0;

   cp0_exc_ctrl #(.EXC_VECTOR(VEC), .IP_HW_W(6)) dut (
      .i_clk(clk), .i_rst(rst), .i_ext_int(ext_int),
      .i_cp0_wen(wen), .i_cp0_ren(ren), .i_cp0_addr(addr),
      .i_cp0_wdata(wdata), .o_cp0_rdata(rdata),
      .i_exc_valid(exc_valid), .i_exc_code(exc_code),
      .i_exc_pc(exc_pc), .i_exc_bd(exc_bd),
      .i_exc_badvaddr(exc_badvaddr), .i_eret(eret),
      .o_int_req(int_req), .o_flush(flush), .o_new_pc(new_pc)
   );

   always #5 clk = ~clk;

   // Model: whole-word register images indexed by CP0 number
   logic [31:0] m_reg [0:31];
   logic        m_tick = 1'b0;
   logic        m_flush = 1'b0;
   logic [31:0] m_newpc = '0;
   logic        m_intreq = 1'b0;
   logic        m_ok = 1'b0;

   task automatic chk(input string n, input logic [31:0] a,
                      input logic [31:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", n, a, e, $time);
      end
   endtask

   task automatic model_step();
      logic [31:0] st, ca, cnt, cmp, epc;
      logic idle;
      if (rst) begin
         for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
         m_reg[12] = 32'h0040_0000;
         m_tick = 1'b0; m_flush = 1'b0; m_newpc = 32'd0;
         m_intreq = 1'b0; m_ok = 1'b1;
         return;
      end
      if (!m_ok) return;
      st = m_reg[12]; ca = m_reg[13]; cnt = m_reg[9];
      cmp = m_reg[11]; epc = m_reg[14];
      idle = !m_flush;
      m_intreq = st[0] & ~st[1] & (|(ca[15:8] & st[15:8]));
      m_reg[13][15:10] = ext_int | {ca[30], 5'd0};
      if (m_tick && (cnt + 32'd1) == cmp) m_reg[13][30] = 1'b1;
      if (m_tick) m_reg[9] = cnt + 32'd1;
      m_flush = idle && (exc_valid || eret);
      if (idle && exc_valid) begin
         if (!st[1]) begin
            m_reg[14] = exc_bd ? exc_pc - 32'd4 : exc_pc;
            m_reg[13][31] = exc_bd;
         end
         m_reg[12][1] = 1'b1;
         m_reg[13][6:2] = exc_code;
         if (exc_code == 5'd4 || exc_code == 5'd5) m_reg[8] = exc_badvaddr;
         m_newpc = VEC;
      end else if (idle && eret) begin
         m_reg[12][1] = 1'b0;
         m_newpc = epc;
      end else if (idle && wen) begin
         case (addr)
            5'd9:  m_reg[9] = wdata;
            5'd11: begin m_reg[11] = wdata; m_reg[13][30] = 1'b0; end
            5'd12: m_reg[12] = (wdata & 32'h0000_FF03) | 32'h0040_0000;
            5'd13: m_reg[13][9:8] = wdata[9:8];
            5'd14: m_reg[14] = wdata;
            default: ;
         endcase
      end
      m_tick = ~m_tick;
   endtask

   function automatic logic [31:0] exp_rd();
      if (!ren) return 32'd0;
      case (addr)
         5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14: return m_reg[addr];
         default: return 32'd0;
      endcase
   endfunction

   always @(posedge clk) model_step();

   always @(negedge clk) begin
      if (m_ok) begin
         chk("m_flush", {31'd0, flush}, {31'd0, m_flush});
         if (m_flush) chk("m_new_pc", new_pc, m_newpc);
         chk("m_int_req", {31'd0, int_req}, {31'd0, m_intreq});
         chk("m_rdata", rdata, exp_rd());
      end
   end

   task automatic cyc();
      @(posedge clk); #1;
      wen = 1'b0; exc_valid = 1'b0; eret = 1'b0; ren = 1'b0;
   endtask

   task automatic rd(input logic [4:0] a, input logic [31:0] e,
                     input string n);
      ren = 1'b1; addr = a;
      @(negedge clk);
      chk(n, rdata, e);
      cyc();
   endtask

   initial begin
      logic seen;
      cyc(); cyc();
      rst = 1'b0;

      // Reset state
      ren = 1'b1; addr = 5'd9;
      @(negedge clk);
      chk("rst_count", rdata, 32'd0);
      chk("rst_flush", {31'd0, flush}, 32'd0);
      chk("rst_int_req", {31'd0, int_req}, 32'd0);
      cyc();
      rd(5'd12, 32'h0040_0000, "rst_status");
      rd(5'd13, 32'd0, "rst_cause");
      rd(5'd14, 32'd0, "rst_epc");

      // Exception in delay slot, AdEL
      exc_valid = 1'b1; exc_code = 5'd4; exc_pc = 32'hBFC0_1000;
      exc_bd = 1'b1; exc_badvaddr = 32'h1234_5677;
      cyc();
      exc_valid = 1'b1; exc_code = 5'd7; exc_pc = 32'd0; exc_bd = 1'b0;
      ren = 1'b1; addr = 5'd14;
      @(negedge clk);
      chk("exc_flush", {31'd0, flush}, 32'd1);
      chk("exc_new_pc", new_pc, VEC);
      chk("exc_epc", rdata, 32'hBFC0_0FFC);
      cyc();
      rd(5'd13, 32'h8000_0010, "exc_cause");
      rd(5'd12, 32'h0040_0002, "exc_status");
      rd(5'd8, 32'h1234_5677, "exc_badvaddr");

      // Nested exception with EXL=1
      exc_valid = 1'b1; exc_code = 5'd10; exc_pc = 32'h8000_0000;
      exc_bd = 1'b0;
      cyc(); cyc();
      rd(5'd14, 32'hBFC0_0FFC, "nest_epc");
      rd(5'd13, 32'h8000_0028, "nest_cause");

      // eret
      eret = 1'b1;
      cyc();
      @(negedge clk);
      chk("eret_new_pc", new_pc, 32'hBFC0_0FFC);
      chk("eret_flush", {31'd0, flush}, 32'd1);
      cyc();
      rd(5'd12, 32'h0040_0000, "eret_status");

      // Simultaneous exception, eret and mtc0
      exc_valid = 1'b1; exc_code = 5'd8; exc_pc = 32'h8000_1234;
      exc_bd = 1'b0; eret = 1'b1;
      wen = 1'b1; addr = 5'd12; wdata = 32'd1;
      cyc();
      @(negedge clk);
      chk("prio_new_pc", new_pc, VEC);
      cyc();
      rd(5'd12, 32'h0040_0002, "prio_status");
      rd(5'd14, 32'h8000_1234, "prio_epc");
      eret = 1'b1;
      cyc();
      @(negedge clk);
      chk("prio_eret_pc", new_pc, 32'h8000_1234);
      cyc();

      // Timer interrupt
      wen = 1'b1; addr = 5'd9; wdata = 32'd0;
      cyc();
      wen = 1'b1; addr = 5'd11; wdata = 32'd5;
      cyc();
      seen = 1'b0;
      for (int n = 0; n < 40 && !seen; n++) begin
         ren = 1'b1; addr = 5'd13;
         @(negedge clk);
         seen = rdata[30];
         cyc();
      end
      chk("ti_set", {31'd0, seen}, 32'd1);
      wen = 1'b1; addr = 5'd12; wdata = 32'h0000_8001;
      cyc();
      seen = 1'b0;
      for (int n = 0; n < 10 && !seen; n++) begin
         @(negedge clk);
         seen = int_req;
         cyc();
      end
      chk("int_req_set", {31'd0, seen}, 32'd1);
      wen = 1'b1; addr = 5'd11; wdata = 32'd100;
      cyc();
      ren = 1'b1; addr = 5'd13;
      @(negedge clk);
      chk("ti_clr", {31'd0, rdata[30]}, 32'd0);
      cyc();
      seen = 1'b1;
      for (int n = 0; n < 10 && seen; n++) begin
         @(negedge clk);
         seen = int_req;
         cyc();
      end
      chk("int_req_clr", {31'd0, seen}, 32'd0);
      wen = 1'b1; addr = 5'd12; wdata = 32'd0;
      cyc();

      // Count write in a tick cycle, then wrap
      for (int n = 0; n < 4 && !m_tick; n++) cyc();
      wen = 1'b1; addr = 5'd9; wdata = 32'hFFFF_FFFF;
      cyc();
      rd(5'd9, 32'hFFFF_FFFF, "cnt_wr");
      rd(5'd9, 32'hFFFF_FFFF, "cnt_hold");
      rd(5'd9, 32'd0, "cnt_wrap");

      // Reset during flush
      exc_valid = 1'b1; exc_code = 5'd5; exc_pc = 32'h8000_0100;
      exc_badvaddr = 32'hDEAD_BEEF;
      cyc();
      rst = 1'b1;
      @(negedge clk);
      chk("rstf_flush1", {31'd0, flush}, 32'd1);
      cyc();
      @(negedge clk);
      chk("rstf_flush0", {31'd0, flush}, 32'd0);
      chk("rstf_new_pc", new_pc, 32'd0);
      rd(5'd12, 32'h0040_0000, "rstf_status");
      rd(5'd8, 32'd0, "rstf_badvaddr");
      rst = 1'b0;

      // Randomized traffic, checked by the model every cycle
      for (int n = 0; n < 3000; n++) begin
         ext_int      = 6'($urandom);
         ren          = 1'($urandom);
         addr         = 5'($urandom_range(7, 15));
         wen          = ($urandom_range(0, 7) == 0);
         wdata        = $urandom;
         exc_valid    = ($urandom_range(0, 15) == 0);
         exc_code     = 5'($urandom);
         exc_pc       = $urandom;
         exc_bd       = 1'($urandom);
         exc_badvaddr = $urandom;
         eret         = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 7) == 0) begin
            wdata = 32'($urandom_range(0, 40));
         end
         @(posedge clk); #1;
      end
      wen = 1'b0; exc_valid = 1'b0; eret = 1'b0; ren = 1'b0;
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
